// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4 / mux4_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one DBITS-wide output channel among four
//   requesters. A plain 4:1 mux (mux4) carries the data. The arbiter drives
//   the mux select and runs the valid/ready handshake on both the requester
//   side and the downstream side. A requester that holds its lock bit keeps
//   the grant for up to MAX_BURST beats.
//
// Ports (mux4_rr_arbiter):
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   req_valid  in   4      per-requester valid (bit i = requester i)
//   req_lock   in   4      requester i wants to keep the grant after this beat
//   req_data0  in   DBITS  requester 0 data
//   req_data1  in   DBITS  requester 1 data
//   req_data2  in   DBITS  requester 2 data
//   req_data3  in   DBITS  requester 3 data
//   req_ready  out  4      one-hot (or zero) ready back to the requesters
//   out_valid  out  1      downstream valid
//   out_ready  in   1      downstream ready
//   out_data   out  DBITS  data of the selected requester
//   out_src    out  2      index of the granted requester (equals sel)
//   busy       out  1      high while a grant is active (XFER)
// ---------------------------------------------------------------------------

// Plain 4:1 multiplexer. Select value 0 picks in1, value 3 picks in4.
module mux4 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  output logic [W-1:0] y
);

  always_comb begin
    unique case (sel)
      2'd0:    y = in1;
      2'd1:    y = in2;
      2'd2:    y = in3;
      default: y = in4;
    endcase
  end

endmodule

module mux4_rr_arbiter #(
  parameter int DBITS     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_lock,
  input  logic [DBITS-1:0] req_data0,
  input  logic [DBITS-1:0] req_data1,
  input  logic [DBITS-1:0] req_data2,
  input  logic [DBITS-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             busy
);

  // One extra bit lets the counter reach MAX_BURST on the final beat
  // without wrapping.
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [1:0]    sel, sel_next;
  logic [1:0]    last, last_next;
  logic [CW-1:0] beat_cnt, beat_cnt_next;
  logic          beat;

  // Round-robin pick: first set bit scanning last+1, last+2, ... (mod 4).
  // The loop runs from the farthest candidate to the nearest, so the nearest
  // valid requester overwrites the result last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                         input logic [1:0] prev);
    logic [1:0] idx;
    rr_pick = prev;
    for (int k = 4; k >= 1; k--) begin
      idx = prev + 2'(k);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

  mux4 #(.W(DBITS)) u_mux (
    .sel (sel),
    .in1 (req_data0),
    .in2 (req_data1),
    .in3 (req_data2),
    .in4 (req_data3),
    .y   (out_data)
  );

  assign beat = out_valid & out_ready;

  // State register. Reset leaves last at 3 so requester 0 is scanned first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= 2'd0;
      last     <= 2'd3;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      sel      <= sel_next;
      last     <= last_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // Next-state logic. A grant ends when the granted requester drops valid,
  // or when a beat completes without lock, or on the last allowed burst beat.
  // A stalled beat (valid high, ready low) holds everything.
  always_comb begin
    state_next    = state;
    sel_next      = sel;
    last_next     = last;
    beat_cnt_next = beat_cnt;
    unique case (state)
      IDLE: begin
        if (req_valid != 4'b0000) begin
          sel_next      = rr_pick(req_valid, last);
          beat_cnt_next = '0;
          state_next    = XFER;
        end
      end
      XFER: begin
        if (!req_valid[sel]) begin
          last_next  = sel;
          state_next = IDLE;
        end else if (out_ready) begin
          beat_cnt_next = beat_cnt + 1'b1;
          if (!req_lock[sel] || beat_cnt == LAST_BEAT) begin
            last_next  = sel;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The ready and valid paths are combinational through the
  // granted index, so a stalled beat completes in the cycle ready rises.
  always_comb begin
    req_ready = 4'b0000;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (state == XFER) begin
      busy           = 1'b1;
      out_valid      = req_valid[sel];
      req_ready[sel] = out_ready;
    end
  end

  assign out_src = sel;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Purpose:
//   Self-checking bench for mux4_rr_arbiter. A table of per-cycle vectors
//   holds inputs and hand-computed expected outputs. It covers single grants,
//   rotation, locked bursts, stalls, lock release by valid drop, and rotation
//   priority. Two hand-written sequences cover a stalled locked burst and an
//   asynchronous reset in the middle of a transfer.
//   Inputs are driven at the falling edge. Outputs are checked 1 ns later,
//   before the next rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mux4_rr_arbiter;

  localparam int DBITS = 32;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_lock;
  logic [DBITS-1:0] req_data0, req_data1, req_data2, req_data3;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DBITS-1:0] out_data;
  logic [1:0]       out_src;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  lk;
    logic        ordy;
    logic [3:0]  rr;
    logic        ov;
    logic [1:0]  src;
    logic        bz;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  mux4_rr_arbiter #(.DBITS(DBITS), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record one vector in the table
  task automatic add_vec(input logic [3:0] rv, input logic [3:0] lk, input logic ordy,
                         input logic [3:0] rr, input logic ov, input logic [1:0] src,
                         input logic bz, input logic [31:0] data);
    vecs[n_vec] = '{rv, lk, ordy, rr, ov, src, bz, data};
    n_vec++;
  endtask

  // Drive the requester-side and downstream inputs
  task automatic apply_stimulus(input logic [3:0] rv, input logic [3:0] lk, input logic ordy);
    req_valid = rv;
    req_lock  = lk;
    out_ready = ordy;
  endtask

  // Compare all outputs against expected values as one comparison
  task automatic check_output(input string name, input logic [3:0] rr, input logic ov,
                              input logic [1:0] src, input logic bz, input logic [31:0] data);
    n_cmp++;
    if (req_ready !== rr || out_valid !== ov || out_src !== src || busy !== bz || out_data !== data) begin
      n_fail++;
      $display("[TB] FAIL %s: got rr=%b ov=%b src=%0d busy=%b data=%h, expected rr=%b ov=%b src=%0d busy=%b data=%h",
               name, req_ready, out_valid, out_src, busy, out_data, rr, ov, src, bz, data);
    end
  endtask

  initial begin
    // Table: rv, lk, ordy | rr, ov, src, busy, data (data0..3 = 0..3)
    // Grant 0 from reset, one beat, back to IDLE
    add_vec(4'b0001, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 32'd0);
    add_vec(4'b0001, 4'b0000, 1, 4'b0001, 1, 2'd0, 1, 32'd0);
    add_vec(4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 32'd0);
    // All four requesting, no lock: 1,2,3,0 with idle bubbles
    add_vec(4'b1111, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 32'd0);
    add_vec(4'b1111, 4'b0000, 1, 4'b0010, 1, 2'd1, 1, 32'd1);
    add_vec(4'b1111, 4'b0000, 1, 4'b0000, 0, 2'd1, 0, 32'd1);
    add_vec(4'b1111, 4'b0000, 1, 4'b0100, 1, 2'd2, 1, 32'd2);
    add_vec(4'b1111, 4'b0000, 1, 4'b0000, 0, 2'd2, 0, 32'd2);
    add_vec(4'b1111, 4'b0000, 1, 4'b1000, 1, 2'd3, 1, 32'd3);
    add_vec(4'b1111, 4'b0000, 1, 4'b0000, 0, 2'd3, 0, 32'd3);
    add_vec(4'b1111, 4'b0000, 1, 4'b0001, 1, 2'd0, 1, 32'd0);
    add_vec(4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 32'd0);
    // Locked burst from requester 1: exactly 4 beats, then re-pick 1
    add_vec(4'b0010, 4'b0010, 1, 4'b0000, 0, 2'd0, 0, 32'd0);
    add_vec(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1, 32'd1);
    add_vec(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1, 32'd1);
    add_vec(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1, 32'd1);
    add_vec(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1, 32'd1);
    add_vec(4'b0010, 4'b0010, 1, 4'b0000, 0, 2'd1, 0, 32'd1);
    add_vec(4'b0010, 4'b0010, 1, 4'b0010, 1, 2'd1, 1, 32'd1);
    // Valid drops mid-burst: ready still follows out_ready, grant releases
    add_vec(4'b0000, 4'b0010, 1, 4'b0010, 0, 2'd1, 1, 32'd1);
    add_vec(4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd1, 0, 32'd1);
    // Grant 2 stalled for 5 cycles, beat when out_ready rises
    add_vec(4'b0100, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, 32'd1);
    for (int i = 0; i < 5; i++)
      add_vec(4'b0100, 4'b0000, 0, 4'b0000, 1, 2'd2, 1, 32'd2);
    add_vec(4'b0100, 4'b0000, 1, 4'b0100, 1, 2'd2, 1, 32'd2);
    add_vec(4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd2, 0, 32'd2);
    // Grant 3 locked, valid dropped after one beat, next pick starts at 0
    add_vec(4'b1000, 4'b1000, 1, 4'b0000, 0, 2'd2, 0, 32'd2);
    add_vec(4'b1000, 4'b1000, 1, 4'b1000, 1, 2'd3, 1, 32'd3);
    add_vec(4'b0000, 4'b1000, 1, 4'b1000, 0, 2'd3, 1, 32'd3);
    add_vec(4'b1111, 4'b0000, 1, 4'b0000, 0, 2'd3, 0, 32'd3);
    add_vec(4'b1111, 4'b0000, 1, 4'b0001, 1, 2'd0, 1, 32'd0);
    add_vec(4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 32'd0);
    // last=0, requests 0 and 3: rotation scans 1,2,3 first and picks 3
    add_vec(4'b1001, 4'b0000, 1, 4'b0000, 0, 2'd0, 0, 32'd0);
    add_vec(4'b1001, 4'b0000, 1, 4'b1000, 1, 2'd3, 1, 32'd3);
    add_vec(4'b0000, 4'b0000, 1, 4'b0000, 0, 2'd3, 0, 32'd3);

    req_data0 = 32'd0;
    req_data1 = 32'd1;
    req_data2 = 32'd2;
    req_data3 = 32'd3;
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    #12;
    // Reset state: outputs idle, sel 0
    check_output("reset_state", 4'b0000, 0, 2'd0, 0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i].rv, vecs[i].lk, vecs[i].ordy);
      #1;
      check_output($sformatf("vec%0d", i), vecs[i].rr, vecs[i].ov, vecs[i].src,
                   vecs[i].bz, vecs[i].data);
    end

    // Locked burst on requester 0 with a stall between beats 1 and 2:
    // the stall must not count, so the grant lasts 5 cycles for 4 beats.
    begin
      logic [4:0] rdy_pat;
      rdy_pat = 5'b11101;
      @(negedge clk);
      apply_stimulus(4'b0001, 4'b0001, 1'b1);
      #1;
      check_output("stall_burst_idle", 4'b0000, 0, 2'd3, 0, 32'd3);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        apply_stimulus(4'b0001, 4'b0001, rdy_pat[c]);
        #1;
        check_output($sformatf("stall_burst_c%0d", c), rdy_pat[c] ? 4'b0001 : 4'b0000,
                     1, 2'd0, 1, 32'd0);
      end
      @(negedge clk);
      apply_stimulus(4'b0000, 4'b0000, 1'b1);
      #1;
      check_output("stall_burst_end", 4'b0000, 0, 2'd0, 0, 32'd0);
    end

    // Asynchronous reset while requester 2 is stalled in XFER
    req_data2 = 32'hDEAD_BEEF;
    req_data0 = 32'hA5A5_0F0F;
    @(negedge clk);
    apply_stimulus(4'b0100, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    check_output("pre_reset_xfer", 4'b0000, 1, 2'd2, 1, 32'hDEAD_BEEF);
    #1;
    reset = 1'b1;
    #1;
    check_output("async_reset", 4'b0000, 0, 2'd0, 0, 32'hA5A5_0F0F);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(4'b1111, 4'b0000, 1'b1);
    #1;
    check_output("post_reset_idle", 4'b0000, 0, 2'd0, 0, 32'hA5A5_0F0F);
    @(negedge clk);
    #1;
    check_output("post_reset_grant0", 4'b0001, 1, 2'd0, 1, 32'hA5A5_0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
